// File: rtl/ps2_host_tx_pkg.sv
// Shared types and defaults for the PS/2 host-to-device transmitter.
package ps2_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_BITS,
    ST_ACK,
    ST_WAITHI
  } state_t;

  localparam int BIT_CNT_W          = 4;
  localparam int DEF_INHIBIT_CYCLES = 2600;
  localparam int DEF_TIMEOUT_CYCLES = 50000;
endpackage

// File: rtl/ps2_host_tx_if.sv
// Host command side plus open-collector PS/2 line signals of the transmitter.
interface ps2_host_tx_if;
  logic [7:0] TX_DATA;
  logic       SEND;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic       PS2_CLK_OE;
  logic       PS2_DATA_OE;
  logic       BUSY;
  logic       DONE;
  logic       ERROR;

  modport slave (
    input  TX_DATA, SEND, PS2_CLK, PS2_DATA,
    output PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR
  );

  modport master (
    output TX_DATA, SEND, PS2_CLK, PS2_DATA,
    input  PS2_CLK_OE, PS2_DATA_OE, BUSY, DONE, ERROR
  );
endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 line with a falling-edge strobe.
module ps2_sync_edge (
  input  logic CLK,
  input  logic RESET_N,
  input  logic i_line,
  output logic o_sync,
  output logic o_fall
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to 1 so an idle (released) line never looks like an edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_fall = r_prev & ~r_sync;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic          CLK,
  input  logic          RESET_N,
  ps2_host_tx_if.slave  bus
);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_t               r_state, w_state_n;
  logic [7:0]           r_data, w_data_n;
  logic                 r_parity, w_parity_n;
  logic [INH_W-1:0]     r_inh, w_inh_n;
  logic [TO_W-1:0]      r_to, w_to_n;
  logic [BIT_CNT_W-1:0] r_bit, w_bit_n;
  logic                 r_clk_oe, w_clk_oe_n;
  logic                 r_data_oe, w_data_oe_n;
  logic                 r_busy, w_busy_n;
  logic                 r_done, w_done_n;
  logic                 r_error, w_error_n;
  logic                 r_nack, w_nack_n;
  logic                 r_dmeta, r_dsync;
  logic                 w_clk_sync, w_clk_fall;

  ps2_sync_edge u_clk_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .i_line  (bus.PS2_CLK),
    .o_sync  (w_clk_sync),
    .o_fall  (w_clk_fall)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dmeta   <= 1'b1;
      r_dsync   <= 1'b1;
      r_state   <= ST_IDLE;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_inh     <= '0;
      r_to      <= '0;
      r_bit     <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_nack    <= 1'b0;
    end else begin
      r_dmeta   <= bus.PS2_DATA;
      r_dsync   <= r_dmeta;
      r_state   <= w_state_n;
      r_data    <= w_data_n;
      r_parity  <= w_parity_n;
      r_inh     <= w_inh_n;
      r_to      <= w_to_n;
      r_bit     <= w_bit_n;
      r_clk_oe  <= w_clk_oe_n;
      r_data_oe <= w_data_oe_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_error   <= w_error_n;
      r_nack    <= w_nack_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_data_n    = r_data;
    w_parity_n  = r_parity;
    w_inh_n     = r_inh;
    w_to_n      = r_to;
    w_bit_n     = r_bit;
    w_clk_oe_n  = r_clk_oe;
    w_data_oe_n = r_data_oe;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;
    w_error_n   = 1'b0;
    w_nack_n    = r_nack;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.SEND) begin
          w_data_n   = bus.TX_DATA;
          w_parity_n = ~^bus.TX_DATA;
          w_inh_n    = '0;
          w_clk_oe_n = 1'b1;
          w_busy_n   = 1'b1;
          w_state_n  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (r_inh == INH_W'(INHIBIT_CYCLES - 1)) begin
          w_data_oe_n = 1'b1;
          w_state_n   = ST_REQ;
        end else begin
          w_inh_n = r_inh + 1'b1;
        end
      end
      ST_REQ: begin
        w_clk_oe_n = 1'b0;
        w_bit_n    = '0;
        w_to_n     = '0;
        w_state_n  = ST_BITS;
      end
      ST_BITS: begin
        // Data byte shifts out LSB first; edges 9 and 10 place parity and stop.
        if (w_clk_fall) begin
          w_to_n  = '0;
          w_bit_n = r_bit + 1'b1;
          if (r_bit < BIT_CNT_W'(8)) begin
            w_data_oe_n = ~r_data[0];
            w_data_n    = {1'b0, r_data[7:1]};
          end else if (r_bit == BIT_CNT_W'(8)) begin
            w_data_oe_n = ~r_parity;
          end else begin
            w_data_oe_n = 1'b0;
            w_state_n   = ST_ACK;
          end
        end else begin
          w_to_n = r_to + 1'b1;
        end
      end
      ST_ACK: begin
        if (w_clk_fall) begin
          w_to_n    = '0;
          w_nack_n  = r_dsync;
          w_state_n = ST_WAITHI;
        end else begin
          w_to_n = r_to + 1'b1;
        end
      end
      ST_WAITHI: begin
        if (w_clk_sync) begin
          w_done_n  = ~r_nack;
          w_error_n = r_nack;
          w_busy_n  = 1'b0;
          w_state_n = ST_IDLE;
        end else begin
          w_to_n = r_to + 1'b1;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    // A silent device abandons the frame: release both lines and flag an error.
    if ((r_state == ST_BITS || r_state == ST_ACK || r_state == ST_WAITHI) &&
        (w_to_n == TO_W'(TIMEOUT_CYCLES))) begin
      w_to_n      = '0;
      w_clk_oe_n  = 1'b0;
      w_data_oe_n = 1'b0;
      w_busy_n    = 1'b0;
      w_done_n    = 1'b0;
      w_error_n   = 1'b1;
      w_state_n   = ST_IDLE;
    end
  end

  assign bus.PS2_CLK_OE  = r_clk_oe;
  assign bus.PS2_DATA_OE = r_data_oe;
  assign bus.BUSY        = r_busy;
  assign bus.DONE        = r_done;
  assign bus.ERROR       = r_error;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector device model with line-bit and outcome scoreboards.
module tb_ps2_host_tx;
  logic CLK = 1'b0;
  logic RESET_N;
  logic dev_clk;
  logic dev_data;

  ps2_host_tx_if bus();

  assign bus.PS2_CLK  = dev_clk  & ~bus.PS2_CLK_OE;
  assign bus.PS2_DATA = dev_data & ~bus.PS2_DATA_OE;

  ps2_host_tx #(.INHIBIT_CYCLES(2600), .TIMEOUT_CYCLES(50000)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_bits[$];
  bit obs_bits[$];
  bit exp_evt[$];
  bit obs_evt[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;
  int multi_cnt = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  // Outcome monitor: 0 = DONE event, 1 = ERROR event.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (bus.DONE)  begin done_cnt++; obs_evt.push_back(1'b0); end
      if (bus.ERROR) begin err_cnt++;  obs_evt.push_back(1'b1); end
      if (bus.DONE && bus.ERROR) both_cnt++;
      if ((bus.DONE && prev_done) || (bus.ERROR && prev_err)) multi_cnt++;
    end
    prev_done = bus.DONE;
    prev_err  = bus.ERROR;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic push_frame(input logic [7:0] d);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    exp_bits.push_back(~^d);
    exp_bits.push_back(1'b1);
  endtask

  task automatic do_send(input logic [7:0] d);
    bus.TX_DATA = d;
    bus.SEND    = 1'b1;
    tick(1);
    bus.SEND    = 1'b0;
  endtask

  // Device model: samples the line just before each falling edge it generates.
  task automatic device_xfer(input bit ack, input int n_edges, input int glitch_edge, output bit ok);
    int w = 0;
    ok = 1'b1;
    while (!(bus.PS2_CLK_OE == 1'b0 && bus.PS2_DATA_OE == 1'b1) && w < 4000) begin
      tick(1);
      w++;
    end
    if (w >= 4000) begin
      ok = 1'b0;
      return;
    end
    tick(10);
    for (int e = 1; e <= n_edges; e++) begin
      obs_bits.push_back(bus.PS2_DATA);
      if (e == 11 && ack) begin
        dev_data = 1'b0;
        tick(4);
      end
      if (e == glitch_edge) begin
        #1 dev_clk = 1'b0;
        #3 dev_clk = 1'b1;
        tick(2);
        #3 dev_clk = 1'b0;
        #10 dev_clk = 1'b1;
        tick(8);
      end else begin
        dev_clk = 1'b0;
        tick(8);
        dev_clk = 1'b1;
        tick(8);
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b1; dev_clk = 1'b1; dev_data = 1'b1;
    bus.SEND = 1'b0; bus.TX_DATA = 8'h00;
    #1 RESET_N = 1'b0;
    #2;
    n_tests++;
    if ({bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY, bus.DONE, bus.ERROR} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY, bus.DONE, bus.ERROR});
    end
    tick(3);
    RESET_N = 1'b1;
    tick(3);
    n_tests++;
    if ({bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY, bus.DONE, bus.ERROR} !== 5'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b expected 00000",
               {bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY, bus.DONE, bus.ERROR});
    end
  endtask

  task automatic test_ack_ed();
    bit ok, o, e;
    int w, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    push_frame(8'hED);
    exp_evt.push_back(1'b0);
    do_send(8'hED);
    n_tests++;
    if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL ed_busy: got %b expected 1", bus.BUSY); end
    device_xfer(1'b1, 11, 0, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL ed_request: got %b expected 1", ok); end
    w = 0;
    while (obs_evt.size() == 0 && w < 200) begin tick(1); w++; end
    n_tests++;
    e = exp_evt.pop_front();
    if (obs_evt.size() == 0) begin
      n_fail++; $display("FAIL ed_outcome: got none expected %0b", e);
    end else begin
      o = obs_evt.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL ed_outcome: got %0b expected %0b", o, e); end
    end
    n_tests++;
    if (obs_bits.size() != 11) begin n_fail++; $display("FAIL ed_nbits: got %0d expected 11", obs_bits.size()); end
    while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
      e = exp_bits.pop_front(); o = obs_bits.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL ed_line_bit: got %0b expected %0b", o, e); end
    end
    exp_bits.delete(); obs_bits.delete();
    n_tests++;
    if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL ed_busy_end: got %b expected 0", bus.BUSY); end
    n_tests++;
    if ((done_cnt - d0) != 1 || (err_cnt - e0) != 0) begin
      n_fail++; $display("FAIL ed_pulses: got done=%0d err=%0d expected done=1 err=0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_nack_f4();
    bit ok, o, e;
    int w, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    push_frame(8'hF4);
    exp_evt.push_back(1'b1);
    do_send(8'hF4);
    device_xfer(1'b0, 11, 0, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL f4_request: got %b expected 1", ok); end
    w = 0;
    while (obs_evt.size() == 0 && w < 200) begin tick(1); w++; end
    n_tests++;
    e = exp_evt.pop_front();
    if (obs_evt.size() == 0) begin
      n_fail++; $display("FAIL f4_outcome: got none expected %0b", e);
    end else begin
      o = obs_evt.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL f4_outcome: got %0b expected %0b", o, e); end
    end
    n_tests++;
    if (obs_bits.size() != 11) begin n_fail++; $display("FAIL f4_nbits: got %0d expected 11", obs_bits.size()); end
    while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
      e = exp_bits.pop_front(); o = obs_bits.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL f4_line_bit: got %0b expected %0b", o, e); end
    end
    exp_bits.delete(); obs_bits.delete();
    n_tests++;
    if ((done_cnt - d0) != 0 || (err_cnt - e0) != 1 || bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL f4_pulses: got done=%0d err=%0d busy=%b expected done=0 err=1 busy=0",
                         done_cnt - d0, err_cnt - e0, bus.BUSY);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit o;
    do_send(8'h55);
    n = 0;
    while (bus.PS2_CLK_OE === 1'b1 && bus.PS2_DATA_OE === 1'b0 && n < 3000) begin tick(1); n++; end
    n_tests++;
    if (n != 2600) begin n_fail++; $display("FAIL inhibit_len: got %0d expected 2600", n); end
    n_tests++;
    if ({bus.PS2_CLK_OE, bus.PS2_DATA_OE} !== 2'b11) begin
      n_fail++; $display("FAIL req_state: got %b expected 11", {bus.PS2_CLK_OE, bus.PS2_DATA_OE});
    end
    tick(1);
    n_tests++;
    if ({bus.PS2_CLK_OE, bus.PS2_DATA_OE} !== 2'b01) begin
      n_fail++; $display("FAIL bits_entry: got %b expected 01", {bus.PS2_CLK_OE, bus.PS2_DATA_OE});
    end
    n = 0;
    while (bus.ERROR !== 1'b1 && n < 60000) begin tick(1); n++; end
    n_tests++;
    if (n != 50000) begin n_fail++; $display("FAIL timeout_len: got %0d expected 50000", n); end
    n_tests++;
    if ({bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY, bus.DONE} !== 4'b0) begin
      n_fail++; $display("FAIL timeout_release: got %b expected 0000",
                         {bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY, bus.DONE});
    end
    tick(1);
    n_tests++;
    if (obs_evt.size() == 0) begin
      n_fail++; $display("FAIL timeout_event: got none expected 1");
    end else begin
      o = obs_evt.pop_front();
      if (o !== 1'b1) begin n_fail++; $display("FAIL timeout_event: got %0b expected 1", o); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, ok2, o, e, busy_after;
    int w, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    busy_after = 1'b0;
    push_frame(8'hED);
    exp_evt.push_back(1'b0);
    do_send(8'hED);
    fork
      device_xfer(1'b1, 11, 0, ok);
      begin
        tick(100);
        do_send(8'h00);
        tick(2600);
        do_send(8'h00);
      end
      begin
        w = 0;
        while (bus.DONE !== 1'b1 && w < 6000) begin tick(1); w++; end
        bus.TX_DATA = 8'h5A;
        bus.SEND    = 1'b1;
        tick(1);
        bus.SEND    = 1'b0;
        busy_after  = bus.BUSY;
      end
    join
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_request: got %b expected 1", ok); end
    n_tests++;
    if (busy_after !== 1'b1) begin n_fail++; $display("FAIL b2b_send_after_done: got busy=%b expected 1", busy_after); end
    while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
      e = exp_bits.pop_front(); o = obs_bits.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_ed_bit: got %0b expected %0b", o, e); end
    end
    exp_bits.delete(); obs_bits.delete();
    push_frame(8'h5A);
    exp_evt.push_back(1'b0);
    device_xfer(1'b1, 11, 0, ok2);
    n_tests++;
    if (ok2 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_request: got %b expected 1", ok2); end
    w = 0;
    while (obs_evt.size() < 2 && w < 200) begin tick(1); w++; end
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      e = exp_evt.pop_front();
      if (obs_evt.size() == 0) begin
        n_fail++; $display("FAIL b2b_outcome: got none expected %0b", e);
      end else begin
        o = obs_evt.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL b2b_outcome: got %0b expected %0b", o, e); end
      end
    end
    while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
      e = exp_bits.pop_front(); o = obs_bits.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_5a_bit: got %0b expected %0b", o, e); end
    end
    exp_bits.delete(); obs_bits.delete();
    n_tests++;
    if ((done_cnt - d0) != 2 || (err_cnt - e0) != 0) begin
      n_fail++; $display("FAIL b2b_pulses: got done=%0d err=%0d expected done=2 err=0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, o, e;
    int w, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    do_send(8'hED);
    device_xfer(1'b1, 5, 0, ok);
    n_tests++;
    if (bus.PS2_DATA_OE !== 1'b1) begin n_fail++; $display("FAIL mid_data_oe: got %b expected 1", bus.PS2_DATA_OE); end
    #3 RESET_N = 1'b0;
    #1;
    n_tests++;
    if ({bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY} !== 3'b0) begin
      n_fail++; $display("FAIL mid_reset_async: got %b expected 000", {bus.PS2_CLK_OE, bus.PS2_DATA_OE, bus.BUSY});
    end
    tick(3);
    RESET_N = 1'b1;
    tick(5);
    obs_bits.delete();
    n_tests++;
    if ((done_cnt - d0) != 0 || (err_cnt - e0) != 0) begin
      n_fail++; $display("FAIL mid_no_pulse: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    push_frame(8'hA5);
    exp_evt.push_back(1'b0);
    do_send(8'hA5);
    device_xfer(1'b1, 11, 0, ok);
    w = 0;
    while (obs_evt.size() == 0 && w < 200) begin tick(1); w++; end
    n_tests++;
    e = exp_evt.pop_front();
    if (obs_evt.size() == 0) begin
      n_fail++; $display("FAIL mid_outcome: got none expected %0b", e);
    end else begin
      o = obs_evt.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL mid_outcome: got %0b expected %0b", o, e); end
    end
    while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
      e = exp_bits.pop_front(); o = obs_bits.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL mid_a5_bit: got %0b expected %0b", o, e); end
    end
    exp_bits.delete(); obs_bits.delete();
  endtask

  task automatic test_glitch();
    bit ok, o, e;
    int w;
    push_frame(8'h3C);
    exp_evt.push_back(1'b0);
    do_send(8'h3C);
    device_xfer(1'b1, 11, 3, ok);
    w = 0;
    while (obs_evt.size() == 0 && w < 200) begin tick(1); w++; end
    n_tests++;
    e = exp_evt.pop_front();
    if (obs_evt.size() == 0) begin
      n_fail++; $display("FAIL glitch_outcome: got none expected %0b", e);
    end else begin
      o = obs_evt.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL glitch_outcome: got %0b expected %0b", o, e); end
    end
    while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
      e = exp_bits.pop_front(); o = obs_bits.pop_front();
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL glitch_bit: got %0b expected %0b", o, e); end
    end
    exp_bits.delete(); obs_bits.delete();
  endtask

  task automatic test_pulse_rules();
    n_tests++;
    if (both_cnt != 0) begin n_fail++; $display("FAIL done_and_error: got %0d expected 0", both_cnt); end
    n_tests++;
    if (multi_cnt != 0) begin n_fail++; $display("FAIL pulse_width: got %0d expected 0", multi_cnt); end
  endtask

  initial begin
    test_reset();
    test_ack_ed();
    test_nack_f4();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_glitch();
    test_pulse_rules();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2600: CLK cycles the PS2 clock is held low before the start bit (at least 100 us at pclk).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: maximum CLK cycles without a device clock falling edge before the transfer is aborted.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock (pclk domain).
REQ-004 SHALL have port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port TX_DATA, input, 8 bits: command byte to send to the keyboard (e.g. 0xED LED set).
REQ-006 SHALL have port SEND, input, 1 bit: one-cycle request strobe.
REQ-007 SHALL have port PS2_CLK, input, 1 bit: raw PS/2 clock line, asynchronous.
REQ-008 SHALL have port PS2_DATA, input, 1 bit: raw PS/2 data line, asynchronous.
REQ-009 SHALL have port PS2_CLK_OE, output, 1 bit: 1 drives the clock line low, 0 releases it.
REQ-010 SHALL have port PS2_DATA_OE, output, 1 bit: 1 drives the data line low, 0 releases it.
REQ-011 SHALL have port BUSY, output, 1 bit: a transfer is in progress.
REQ-012 SHALL have port DONE, output, 1 bit: one-cycle pulse when the device acknowledges.
REQ-013 SHALL have port ERROR, output, 1 bit: one-cycle pulse on NACK or timeout.

Function
REQ-014 SHALL synchronise PS2_CLK and PS2_DATA through 2 flops; a falling edge SHALL be a synced 1 followed by a synced 0.
REQ-015 SHALL implement the states IDLE, INHIBIT, REQ, BITS, ACK, WAITHI.
REQ-016 SHALL accept SEND only in IDLE: latch TX_DATA, compute odd parity (~^TX_DATA), go to INHIBIT, and assert BUSY on the next cycle; SEND SHALL be ignored while BUSY=1.
REQ-017 In INHIBIT, SHALL hold PS2_CLK_OE=1 for exactly INHIBIT_CYCLES cycles, then set PS2_DATA_OE=1 (start bit) with PS2_CLK_OE still 1 for one cycle (REQ state).
REQ-018 On leaving REQ, SHALL set PS2_CLK_OE=0 and keep it 0 until IDLE is reached again, and SHALL enter BITS with the edge count set to 0.
REQ-019 In BITS, on falling edges 1..8 SHALL set PS2_DATA_OE=~bit[k-1], LSB first.
REQ-020 On falling edge 9, SHALL set PS2_DATA_OE=~parity.
REQ-021 On falling edge 10, SHALL set PS2_DATA_OE=0 (stop bit) and enter ACK.
REQ-022 In ACK, on the next falling edge SHALL sample synced PS2_DATA: 0 = ACK, 1 = NACK; then enter WAITHI.
REQ-023 In WAITHI, SHALL wait for synced PS2_CLK=1, then pulse DONE (ACK) or ERROR (NACK), drop BUSY, and return to IDLE, all in the same cycle.
REQ-024 SHALL clear the timeout counter on every falling edge and on entry to BITS; if the count reaches TIMEOUT_CYCLES in BITS, ACK or WAITHI, SHALL release both lines, pulse ERROR, and return to IDLE.
REQ-025 SHALL NOT generate both DONE and ERROR in the same cycle.
REQ-026 SHALL keep DONE and ERROR at 0 except for single-cycle pulses.
REQ-027 SHALL ignore falling edges seen during IDLE, INHIBIT and REQ.
REQ-028 SHALL allow a new SEND to be accepted in the cycle after DONE/ERROR.

Reset
REQ-029 RESET_N=0 SHALL immediately force: state IDLE; PS2_CLK_OE=PS2_DATA_OE=0; BUSY=DONE=ERROR=0; counters and synchronisers set to 0 (synchronisers to 1, i.e. idle line).
REQ-030 Reset asserted mid-transfer SHALL release both lines with no DONE/ERROR pulse.

Structure
REQ-031 Package ps2_pkg SHALL hold the state enum, the bit-count width (4) and the default INHIBIT/TIMEOUT constants.
REQ-032 Synchroniser plus falling-edge detector SHALL be sub-module ps2_sync_edge, instantiated for the clock line (data line uses the sync path only).

Verification
REQ-033 SEND with TX_DATA=0xED, device model clocks 11 edges and pulls data low on the 11th -> line bits observed LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1; DONE pulse; BUSY 0.
REQ-034 TX_DATA=0xF4 with device leaving data high on the 11th edge -> parity bit 0 observed; ERROR pulse; no DONE.
REQ-035 SEND then no device clocks -> PS2_CLK_OE=1 for exactly 2600 cycles; after 50000 idle cycles in BITS -> ERROR pulse, both OE=0, BUSY=0.
REQ-036 Second SEND (0x00) pulsed while BUSY during 0xED transfer -> ignored; 0xED bits unchanged; exactly one DONE.
REQ-037 RESET_N low after edge 5 -> OE outputs 0 asynchronously; no DONE/ERROR; SEND after reset release -> full clean transfer.
REQ-038 PS2_CLK glitch (1-cycle low pulse) asynchronous to CLK -> counted as exactly one edge only if it survives the 2-flop sync; no double-count.
